res_ram_arbiter: RTL

//  Shares the single-port result RAM (8b x 16384, read latched at negedge, write at posedge) between NREQ DT engines (loader, fwd pass, bwd pass).

---
 rtl/res_ram_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/res_ram_arbiter.sv
// Result RAM arbiter: shares one single-port RAM among NREQ engines with round-robin grant,
// bounded lock bursts and a 2-cycle read return. Define RES_ARB_FIXED_PRIO_EN for fixed priority.
module res_ram_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned AW       = 14,
    parameter int unsigned DW       = 8,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ-1:0]    lock_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic               busy_o,
    output logic               res_rd_o,
    output logic               res_wr_o,
    output logic [AW-1:0]      res_addr_o,
    output logic [DW-1:0]      res_do_o,
    input  logic [DW-1:0]      res_di_i
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    typedef logic [IW-1:0] idx_t;
    typedef logic [CW-1:0] cnt_t;

    idx_t            owner_q, owner_d;
    logic            locked_q, locked_d;
    cnt_t            lock_cnt_q, lock_cnt_d;
    idx_t            start_idx;

    logic            res_rd_q, res_rd_d;
    logic            res_wr_q, res_wr_d;
    logic [AW-1:0]   res_addr_q, res_addr_d;
    logic [DW-1:0]   res_do_q, res_do_d;
    idx_t            rd_idx_q, rd_idx_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            cap_hit;
    logic            acc_vld;
    idx_t            acc_idx;
    idx_t            cand;

`ifdef RES_ARB_FIXED_PRIO_EN
    assign start_idx = '0;
`else
    idx_t rr_ptr_q, rr_ptr_d;
    assign start_idx = rr_ptr_q;
`endif

    // Arbitration: a locked owner under its burst cap wins outright; at the cap it sits out once.
    always_comb begin
        cap_hit = locked_q && (lock_cnt_q >= cnt_t'(LOCK_MAX));
        acc_vld = 1'b0;
        acc_idx = '0;
        cand    = '0;
        if (locked_q && req_i[owner_q] && !cap_hit) begin
            acc_vld = 1'b1;
            acc_idx = owner_q;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = idx_t'((32'(start_idx) + k) % NREQ);
                if (!acc_vld && req_i[cand] && !(cap_hit && (cand == owner_q))) begin
                    acc_vld = 1'b1;
                    acc_idx = cand;
                end
            end
        end
    end

    assign gnt_o = (acc_vld && reset) ? (NREQ'(1) << acc_idx) : '0;

    always_comb begin
        owner_d    = owner_q;
        locked_d   = 1'b0;
        lock_cnt_d = '0;
`ifndef RES_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        if (acc_vld) begin
`ifndef RES_ARB_FIXED_PRIO_EN
            rr_ptr_d = idx_t'((32'(acc_idx) + 1) % NREQ);
`endif
            if (lock_i[acc_idx]) begin
                owner_d    = acc_idx;
                locked_d   = 1'b1;
                lock_cnt_d = (locked_q && (owner_q == acc_idx)) ? lock_cnt_q + cnt_t'(1)
                                                               : cnt_t'(1);
            end
        end
    end

    // Stage 1 drives the RAM; stage 2 returns read data to the requester that issued it.
    always_comb begin
        res_rd_d   = acc_vld && !we_i[acc_idx];
        res_wr_d   = acc_vld && we_i[acc_idx];
        res_addr_d = res_addr_q;
        res_do_d   = res_do_q;
        rd_idx_d   = rd_idx_q;
        if (acc_vld) begin
            res_addr_d = addr_i[acc_idx*AW +: AW];
            res_do_d   = wdata_i[acc_idx*DW +: DW];
            rd_idx_d   = acc_idx;
        end
        rvalid_d = res_rd_q ? (NREQ'(1) << rd_idx_q) : '0;
        rdata_d  = res_rd_q ? res_di_i : rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= '0;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
`ifndef RES_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
            res_rd_q   <= 1'b0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
            rd_idx_q   <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            owner_q    <= owner_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
`ifndef RES_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
            res_rd_q   <= res_rd_d;
            res_wr_q   <= res_wr_d;
            res_addr_q <= res_addr_d;
            res_do_q   <= res_do_d;
            rd_idx_q   <= rd_idx_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign res_rd_o   = res_rd_q;
    assign res_wr_o   = res_wr_q;
    assign res_addr_o = res_addr_q;
    assign res_do_o   = res_do_q;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign busy_o     = res_rd_q | res_wr_q | (|rvalid_q);

    // A waiting requester must keep its command stable until granted.
    for (genvar g = 0; g < NREQ; g++) begin : g_hold_chk
        a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
            (req_i[g] && !gnt_o[g]) |=> (!req_i[g] || ($stable(addr_i[g*AW +: AW]) &&
                                          $stable(we_i[g]) && $stable(wdata_i[g*DW +: DW]))));
    end

endmodule
